// File: rtl/booth_mul_unit.sv
// rtl/booth_mul_unit.sv - sequential signed 32x32->64 Booth multiplier for the ALU multiply handshake
//
// Purpose:
//   Computes multiplicand x multiplier (both signed, two's complement) over
//   several cycles and holds the product with a sticky done flag until the
//   ALU acknowledges it.
//
// Configuration macro: BOOTH_RADIX4_EN
//   defined   -> radix-4 Booth recoding, 16 steps, latency 16 cycles
//   undefined -> radix-2 Booth recoding, 32 steps, latency 32 cycles
//
// Ports:
//   clk            in   1   clock, rising edge
//   reset_n        in   1   asynchronous active-low reset
//   mul_start      in   1   level request; a job is accepted on its rising edge in IDLE
//   multiplicand   in  32   signed operand M, sampled at accept
//   multiplier     in  32   signed operand Q, sampled at accept
//   muldone_clear  in   1   acknowledge; releases mul_done while in DONE
//   mul_result     out 64   signed product, registered
//   mul_done       out  1   product valid, sticky until acknowledged

module booth_mul_unit (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mul_start,
    input  logic [31:0] multiplicand,
    input  logic [31:0] multiplier,
    input  logic        muldone_clear,
    output logic [63:0] mul_result,
    output logic        mul_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

`ifdef BOOTH_RADIX4_EN
    localparam logic [4:0] LAST_STEP = 5'd15;
`else
    localparam logic [4:0] LAST_STEP = 5'd31;
`endif

    state_t      state_q, state_d;
    logic        mul_start_q;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic        qm1_q, qm1_d;
    logic [33:0] acc_q, acc_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] result_q, result_d;
    logic        done_q, done_d;

    logic        start_edge;

    // One Booth step computed from the current registers.
    logic [33:0] m_ext;
    logic [33:0] pp;
    logic [33:0] sum;
    logic [33:0] acc_step;
    logic [31:0] q_step;
    logic        qm1_step;

    assign start_edge = mul_start & ~mul_start_q;

    assign mul_result = result_q;
    assign mul_done   = done_q;

`ifdef BOOTH_RADIX4_EN
    logic [33:0] m2_ext;

    always_comb begin
        m_ext  = {{2{mcand_q[31]}}, mcand_q};
        // 2M kept in 34 bits so that 2 x 0x80000000 does not overflow.
        m2_ext = {mcand_q[31], mcand_q, 1'b0};
        pp     = '0;
        case ({mplier_q[1:0], qm1_q})
            3'b001, 3'b010: pp = m_ext;
            3'b011:         pp = m2_ext;
            3'b100:         pp = 34'd0 - m2_ext;
            3'b101, 3'b110: pp = 34'd0 - m_ext;
            default:        pp = '0;
        endcase
        sum      = acc_q + pp;
        // Arithmetic shift of {acc, Q, q_m1} right by two.
        acc_step = {{2{sum[33]}}, sum[33:2]};
        q_step   = {sum[1:0], mplier_q[31:2]};
        qm1_step = mplier_q[1];
    end
`else
    always_comb begin
        m_ext = {{2{mcand_q[31]}}, mcand_q};
        pp    = '0;
        case ({mplier_q[0], qm1_q})
            2'b01:   pp = m_ext;
            2'b10:   pp = 34'd0 - m_ext;
            default: pp = '0;
        endcase
        sum      = acc_q + pp;
        // Arithmetic shift of {acc, Q, q_m1} right by one.
        acc_step = {sum[33], sum[33:1]};
        q_step   = {sum[0], mplier_q[31:1]};
        qm1_step = mplier_q[0];
    end
`endif

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        qm1_d    = qm1_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        done_d   = done_q;

        case (state_q)
            ST_IDLE: begin
                if (start_edge) begin
                    mcand_d  = multiplicand;
                    mplier_d = multiplier;
                    acc_d    = '0;
                    qm1_d    = 1'b0;
                    cnt_d    = '0;
                    result_d = '0;
                    state_d  = ST_EXEC;
                end
            end

            ST_EXEC: begin
                acc_d    = acc_step;
                mplier_d = q_step;
                qm1_d    = qm1_step;
                cnt_d    = cnt_q + 5'd1;
                if (cnt_q == LAST_STEP) begin
                    // The upper acc bits are pure sign extension by now.
                    result_d = {acc_step[31:0], q_step};
                    done_d   = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_DONE;
                end
            end

            ST_DONE: begin
                // A start edge arriving here is dropped; mul_start_q still
                // tracks the level, so the ALU must lower and raise it again.
                if (muldone_clear) begin
                    done_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            mul_start_q <= 1'b0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            qm1_q       <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mul_start_q <= mul_start;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            qm1_q       <= qm1_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_booth_mul_unit.sv
// tb/tb_booth_mul_unit.sv - scoreboard bench for booth_mul_unit

module tb_booth_mul_unit;

`ifdef BOOTH_RADIX4_EN
    localparam int LAT = 16;
`else
    localparam int LAT = 32;
`endif

    logic        clk;
    logic        reset_n;
    logic        mul_start;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        muldone_clear;
    logic [63:0] mul_result;
    logic        mul_done;

    int n_total;
    int n_pass;

    logic [63:0] sb_q[$];

    booth_mul_unit dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .mul_start     (mul_start),
        .multiplicand  (multiplicand),
        .multiplier    (multiplier),
        .muldone_clear (muldone_clear),
        .mul_result    (mul_result),
        .mul_done      (mul_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] model(input logic [31:0] m, input logic [31:0] q);
        longint a;
        longint b;
        a = longint'(signed'(m));
        b = longint'(signed'(q));
        return 64'(a * b);
    endfunction

    // Drives operands and raises mul_start; returns just after the accept edge.
    task automatic start_job(input logic [31:0] m, input logic [31:0] q);
        sb_q.push_back(model(m, q));
        multiplicand = m;
        multiplier   = q;
        mul_start    = 1'b1;
        tick();
    endtask

    task automatic wait_done(input string tag, input int elapsed);
        int cyc;
        logic [63:0] exp;
        cyc = elapsed;
        while (!mul_done && cyc < LAT + 8) begin
            tick();
            cyc++;
        end
        check({tag, "_latency"}, 64'(cyc), 64'(LAT));
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 64'(1), 64'(0));
        end else begin
            exp = sb_q.pop_front();
            check({tag, "_result"}, mul_result, exp);
        end
    endtask

    task automatic clear_done(input string tag);
        muldone_clear = 1'b1;
        mul_start     = 1'b0;
        tick();
        muldone_clear = 1'b0;
        check({tag, "_cleared"}, 64'(mul_done), 64'(0));
    endtask

    logic [31:0] tab_m[5] = '{32'h0000_0003, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h1234_5678};
    logic [31:0] tab_q[5] = '{32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000};

    initial begin
        logic [63:0] held;
        logic [31:0] rm;
        logic [31:0] rq;
        n_total       = 0;
        n_pass        = 0;
        reset_n       = 1'b0;
        mul_start     = 1'b0;
        multiplicand  = '0;
        multiplier    = '0;
        muldone_clear = 1'b0;
        tick();
        tick();
        check("reset_done", 64'(mul_done), 64'(0));
        check("reset_result", mul_result, 64'(0));
        reset_n = 1'b1;
        tick();

        // 3 x 5 with mul_start held long after completion: no restart.
        start_job(tab_m[0], tab_q[0]);
        wait_done("m3q5", 0);
        for (int i = 0; i < 4; i++) tick();
        check("m3q5_hold_done", 64'(mul_done), 64'(1));
        check("m3q5_hold_result", mul_result, 64'h0000_0000_0000_000F);
        clear_done("m3q5");

        // Boundary operand table.
        for (int i = 1; i < 5; i++) begin
            start_job(tab_m[i], tab_q[i]);
            wait_done($sformatf("tab%0d", i), 0);
            clear_done($sformatf("tab%0d", i));
        end

        // Random operands.
        for (int i = 0; i < 4; i++) begin
            start_job($urandom, $urandom);
            wait_done($sformatf("rnd%0d", i), 0);
            clear_done($sformatf("rnd%0d", i));
        end

        // Clear and a fresh start edge in the same DONE cycle.
        start_job(32'hFFFF_FFF0, 32'h0000_0011);
        wait_done("simul", 0);
        held = mul_result;
        mul_start = 1'b0;
        tick();
        check("simul_still_done", 64'(mul_done), 64'(1));
        mul_start     = 1'b1;
        multiplicand  = 32'h0000_0077;
        multiplier    = 32'h0000_0002;
        muldone_clear = 1'b1;
        tick();
        muldone_clear = 1'b0;
        check("simul_cleared", 64'(mul_done), 64'(0));
        for (int i = 0; i < LAT + 4; i++) tick();
        check("simul_no_job_done", 64'(mul_done), 64'(0));
        check("simul_result_kept", mul_result, held);
        mul_start = 1'b0;
        tick();
        start_job(32'h0000_0077, 32'h0000_0002);
        wait_done("simul_next", 0);
        clear_done("simul_next");

        // Asynchronous reset in the middle of EXEC.
        start_job(32'h0BAD_F00D, 32'h1357_9BDF);
        for (int i = 0; i < 6; i++) tick();
        reset_n = 1'b0;
        #1;
        check("midreset_done", 64'(mul_done), 64'(0));
        check("midreset_result", mul_result, 64'(0));
        sb_q.delete();
        mul_start = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        start_job(32'hFFFF_FFF9, 32'h0000_0009);
        wait_done("after_reset", 0);
        check("after_reset_const", mul_result, 64'hFFFF_FFFF_FFFF_FFC1);
        clear_done("after_reset");

        // Operand change and stray clear during EXEC.
        rm = $urandom;
        rq = $urandom;
        start_job(rm, rq);
        tick();
        tick();
        multiplicand  = ~rm;
        multiplier    = rq ^ 32'h5A5A_5A5A;
        muldone_clear = 1'b1;
        tick();
        muldone_clear = 1'b0;
        check("exec_clear_ignored", 64'(mul_done), 64'(0));
        wait_done("opchange", 3);
        tick();
        check("opchange_done_sticky", 64'(mul_done), 64'(1));
        clear_done("opchange");

        check("sb_drained", 64'(sb_q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/booth_mul_unit.md
# booth_mul_unit

Sequential signed 32×32→64 multiplier that answers the ALU's multiply handshake (`mul_start`, `multiplicand`, `multiplier` in; `mul_result`, `mul_done` out; `muldone_clear` in). It sits beside the ALU calculation block and is started when the ALU control FSM enters its MUL state. It holds the product and `mul_done` until the ALU acknowledges with `muldone_clear` during result push. Booth recoding uses radix-4 by default, with a radix-2 fallback selected at compile time.

## Interface
- Parameters: none. Operand width is fixed at 32 bits; product width is fixed at 64 bits.
- `clk` in 1: single clock; all state updates on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `mul_start` in 1: level request from the ALU, held high for the whole MUL state. A job starts on its rising edge only.
- `multiplicand` in 32: signed operand M; valid while `mul_start`=1.
- `multiplier` in 32: signed operand Q; valid while `mul_start`=1.
- `muldone_clear` in 1: acknowledge pulse from the ALU; releases `mul_done`.
- `mul_result` out 64: signed product M×Q, two's complement.
- `mul_done` out 1: product valid; sticky until acknowledged.

## Operation
- FSM has three states: IDLE, EXEC, DONE. Reset state is IDLE.
- Start detect: `start_edge = mul_start & ~mul_start_q`, where `mul_start_q` is a register that resets to 0.
- **IDLE:**
  - On `start_edge`, latch M and Q, clear the accumulator and `q_m1`, zero the iteration counter, clear `mul_result` to 0, and go to EXEC.
  - Without `start_edge`, stay in IDLE.
- **EXEC:** one Booth step per cycle.
  - Accumulator is 34 bits, sign-extended.
  - Radix-4 recode triple {q1,q0,q_m1}:
    - 000 or 111 → +0
    - 001 or 010 → +M
    - 011 → +2M
    - 100 → −2M
    - 101 or 110 → −M
  - After the add, arithmetic-shift the {acc,Q,q_m1} register right by 2.
  - After 16 steps, write `mul_result` = low 64 bits of {acc,Q}, set `mul_done`=1, and go to DONE.
- **DONE:** hold `mul_result` and `mul_done`=1.
  - On `muldone_clear`=1, clear `mul_done` and go to IDLE.
  - `mul_result` keeps the last product until the next accepted start.
- Ignored events:
  - `start_edge` while in EXEC or DONE (no restart, no operand re-latch).
  - `muldone_clear` in IDLE or EXEC.
- Simultaneous `muldone_clear` and `start_edge` in DONE: the clear takes effect and the start edge is discarded. A new job requires `mul_start` to drop and rise again.
- Operand changes after the accept edge have no effect on the running job.
- Arithmetic: full-range signed. 0x80000000 × 0x80000000 = 0x4000_0000_0000_0000 with no overflow. 2M and −2M are formed in 34 bits.

## Timing
- Reset: `mul_result`=0, `mul_done`=0, state IDLE, counter 0, `mul_start_q`=0. Reset takes effect immediately and asynchronously, including mid-EXEC; the partial job is lost.
- Accept at edge N (IDLE, `start_edge`). EXEC steps occur at edges N+1 through N+16.
- `mul_done` and `mul_result` are valid after edge N+16, giving a latency of 16 cycles (32 in radix-2).
- `mul_done` falls after the edge that samples `muldone_clear`=1 in DONE. The earliest next accept is 2 edges later, since a `mul_start` low cycle is required.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro `BOOTH_RADIX4_EN`.
- **Defined:** radix-4 recoding as above; 16 EXEC steps; latency 16.
- **Undefined:** radix-2 recoding on {q0,q_m1}:
  - 01 → +M
  - 10 → −M
  - 00 or 11 → +0
  - Shift right by 1 per step; 32 EXEC steps; latency 32.
- Interface and handshake are identical in both builds.

## Test plan
- M=3, Q=5, start pulse held 20 cycles → `mul_result`=0x0000_0000_0000_000F; `mul_done` rises exactly 16 cycles after accept (32 without macro); no restart while `mul_start` stays high.
- M=0xFFFFFFFF, Q=0xFFFFFFFF → 0x0000_0000_0000_0001. M=0x7FFFFFFF, Q=0xFFFFFFFF → 0xFFFF_FFFF_8000_0001.
- M=Q=0x80000000 → 0x4000_0000_0000_0000. M=0x12345678, Q=0 → 0.
- In DONE, assert `muldone_clear` and a fresh `start_edge` in the same cycle → `mul_done`=0, state IDLE, no new job. The next `mul_start` 0→1 starts normally.
- Drive `reset_n` low at EXEC step 7 → `mul_done`=0 and `mul_result`=0 immediately. A subsequent job M=−7, Q=9 gives 0xFFFF_FFFF_FFFF_FFC1.
- Change M and Q mid-EXEC, and pulse `muldone_clear` during EXEC → the product matches the latched operands and `mul_done` is unaffected.
